// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: widths, opcode
// constants, state encoding and the instruction word layout.
// Optional feature macro used by the sequencer files: CARRY_FLAG_EN.
package instr_sequencer_pkg;

    localparam int REG_IDX_WIDTH = 3;
    localparam int DATA_WIDTH    = 8;

    localparam logic [1:0] OP_MOV  = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_LDI  = 2'b11;
    localparam logic [2:0] HALT_RS = 3'b111;

    localparam logic [2:0] ST_FETCH     = 3'd0;
    localparam logic [2:0] ST_DECODE    = 3'd1;
    localparam logic [2:0] ST_READ_S    = 3'd2;
    localparam logic [2:0] ST_READ_D    = 3'd3;
    localparam logic [2:0] ST_FETCH_IMM = 3'd4;
    localparam logic [2:0] ST_WB_ARM    = 3'd5;
    localparam logic [2:0] ST_WB_DATA   = 3'd6;
    localparam logic [2:0] ST_HALT      = 3'd7;

    typedef enum logic [2:0] {
        FETCH     = ST_FETCH,
        DECODE    = ST_DECODE,
        READ_S    = ST_READ_S,
        READ_D    = ST_READ_D,
        FETCH_IMM = ST_FETCH_IMM,
        WB_ARM    = ST_WB_ARM,
        WB_DATA   = ST_WB_DATA,
        HALT      = ST_HALT
    } seqState;

    typedef logic [DATA_WIDTH-1:0]    dataWord;
    typedef logic [REG_IDX_WIDTH-1:0] regIdx;

    typedef struct packed {
        logic [1:0] op;
        regIdx      rd;
        regIdx      rs;
    } instrWord;

    // Opcode 11 doubles as HALT when the source field is all ones
    function automatic logic isHalt(instrWord instr);
        return (instr.op == OP_LDI) && (instr.rs == HALT_RS);
    endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Fetch bus plus register-file port bundle between the sequencer
// (master) and the instruction memory / register file (slave).
interface instr_sequencer_if #(
    parameter int ADDR_WIDTH = 8
);
    import instr_sequencer_pkg::*;

    logic [ADDR_WIDTH-1:0] InstrAddr;
    logic                  InstrReq;
    dataWord               InstrData;
    logic                  InstrValid;
    regIdx                 ReadRegister;
    dataWord               ReadData;
    regIdx                 WriteRegister;
    dataWord               WriteData;
    logic                  WriteSignal;
    logic                  Halted;

    modport master (
        output InstrAddr, InstrReq, ReadRegister,
        output WriteRegister, WriteData, WriteSignal, Halted,
        input  InstrData, InstrValid, ReadData
    );

    modport slave (
        input  InstrAddr, InstrReq, ReadRegister,
        input  WriteRegister, WriteData, WriteSignal, Halted,
        output InstrData, InstrValid, ReadData
    );

endinterface

// File: rtl/instr_sequencer_alu.sv
// seq_alu: combinational result selection for write-back.
// With CARRY_FLAG_EN defined it also reports carry (ADD) / borrow (SUB).
module seq_alu
    import instr_sequencer_pkg::*;
(
    input  dataWord    A,
    input  dataWord    B,
    input  logic [1:0] Op,
    output dataWord    Result
`ifdef CARRY_FLAG_EN
    ,
    output logic       CarryOut
`endif
);

    // Pick the write-back value; MOV and LDI pass A straight through
    always_comb begin
        Result = A;
`ifdef CARRY_FLAG_EN
        CarryOut = 1'b0;
        case (Op)
            OP_ADD:  {CarryOut, Result} = {1'b0, B} + {1'b0, A};
            OP_SUB:  {CarryOut, Result} = {1'b0, B} - {1'b0, A};
            default: Result = A;
        endcase
`else
        case (Op)
            OP_ADD:  Result = B + A;
            OP_SUB:  Result = B - A;
            default: Result = A;
        endcase
`endif
    end

endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle fetch/decode/write-back controller in
// front of the 8x8 register file. Writes are armed one cycle before the
// address/data change, because the file commits on that change.
// Optional feature macro: CARRY_FLAG_EN adds the Carry output.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input logic Clock,
    input logic Reset,
    instr_sequencer_if.master bus
`ifdef CARRY_FLAG_EN
    ,
    output logic Carry
`endif
);

    seqState               state;
    seqState               nextState;
    instrWord              ir;
    dataWord               regA;
    dataWord               regB;
    dataWord               aluResult;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  fetchDone;
`ifdef CARRY_FLAG_EN
    logic                  aluCarry;
`endif

    // A fetch completes only while we are actually requesting
    assign fetchDone     = bus.InstrReq && bus.InstrValid;
    assign bus.InstrAddr = pc;
    assign bus.Halted    = (state == HALT);

    seq_alu alu (
        .A      (regA),
        .B      (regB),
        .Op     (ir.op),
        .Result (aluResult)
`ifdef CARRY_FLAG_EN
        ,
        .CarryOut (aluCarry)
`endif
    );

    // State register
    // NOTE: sequential blocks use non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) state <= FETCH;
        else        state <= nextState;
    end

    // Next-state decode
    // NOTE: nextState gets its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        nextState = state;
        case (state)
            FETCH:     if (fetchDone) nextState = DECODE;
            DECODE: begin
                if (isHalt(ir))            nextState = HALT;
                else if (ir.op == OP_LDI)  nextState = FETCH_IMM;
                else                       nextState = READ_S;
            end
            READ_S:    nextState = (ir.op == OP_MOV) ? WB_ARM : READ_D;
            READ_D:    nextState = WB_ARM;
            FETCH_IMM: if (fetchDone) nextState = WB_ARM;
            WB_ARM:    nextState = WB_DATA;
            WB_DATA:   nextState = FETCH;
            HALT:      nextState = HALT;
            default:   nextState = FETCH;
        endcase
    end

    // Datapath and registered outputs, all derived from the upcoming state
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            pc                <= RESET_PC;
            ir                <= '0;
            regA              <= '0;
            regB              <= '0;
            bus.InstrReq      <= 1'b0;
            bus.ReadRegister  <= '0;
            bus.WriteRegister <= '0;
            bus.WriteData     <= '0;
            bus.WriteSignal   <= 1'b0;
`ifdef CARRY_FLAG_EN
            Carry             <= 1'b0;
`endif
        end else begin
            bus.InstrReq    <= (nextState == FETCH) || (nextState == FETCH_IMM);
            bus.WriteSignal <= (nextState == WB_ARM) || (nextState == WB_DATA);

            if (fetchDone)                     pc   <= pc + 1'b1;
            if (state == FETCH && fetchDone)     ir   <= bus.InstrData;
            if (state == FETCH_IMM && fetchDone) regA <= bus.InstrData;
            if (state == READ_S)                 regA <= bus.ReadData;
            if (state == READ_D)                 regB <= bus.ReadData;

            // Read address is set on entry so the READ state sees settled data
            if (nextState == READ_S) bus.ReadRegister <= ir.rs;
            if (nextState == READ_D) bus.ReadRegister <= ir.rd;

            // Address/data move only in WB_DATA, one cycle after the enable rose
            if (nextState == WB_DATA) begin
                bus.WriteRegister <= ir.rd;
                bus.WriteData     <= aluResult;
`ifdef CARRY_FLAG_EN
                if (ir.op == OP_ADD || ir.op == OP_SUB) Carry <= aluCarry;
`endif
            end
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: instruction memory with per-address
// wait states, a register file that commits on address/data change while
// enabled, a vector table for the instruction stream, and hand-written
// reset/halt sequences. Builds with or without CARRY_FLAG_EN.
module tb_instr_sequencer;

    localparam logic [7:0] RESET_PC_TB = 8'hFD;
`ifdef CARRY_FLAG_EN
    localparam logic [7:0] ADD_WD = 8'h01;
    localparam logic       ADD_C  = 1'b1;
`else
    localparam logic [7:0] ADD_WD = 8'h08;
    localparam logic       ADD_C  = 1'b0;
`endif

    typedef struct {
        string      name;
        logic [2:0] wr;
        logic [7:0] wd;
        int         lat;
        logic [7:0] pcAfter;
        logic [2:0] rrAfter;
        logic       carry;
    } vecRec;

    logic Clock = 1'b0;
    logic Reset = 1'b1;
`ifdef CARRY_FLAG_EN
    logic Carry;
`endif

    instr_sequencer_if #(.ADDR_WIDTH(8)) bus ();

    instr_sequencer #(.ADDR_WIDTH(8), .RESET_PC(RESET_PC_TB)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
`ifdef CARRY_FLAG_EN
        ,
        .Carry (Carry)
`endif
    );

    always #5 Clock = ~Clock;

    logic [7:0] regs    [8];
    logic [7:0] mem     [256];
    int         memWait [256];
    int         checks = 0;
    int         errors = 0;
    int         reqAge = 0;
    logic       reqPrev = 1'b0;
    logic [2:0] lastWr = '0;
    logic [7:0] lastWd = '0;
    int         writeCount = 0;

    assign bus.ReadData = regs[bus.ReadRegister];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Drive memory for the current cycle, advance one edge, apply file writes
    task automatic stepCycle();
        logic [7:0] a;
        if (bus.InstrReq) reqAge = reqPrev ? reqAge + 1 : 0;
        else              reqAge = 0;
        reqPrev = bus.InstrReq;
        a = bus.InstrAddr;
        bus.InstrValid = bus.InstrReq && (reqAge >= 1 + memWait[a]);
        bus.InstrData  = bus.InstrValid ? mem[a] : 8'h00;
        @(posedge Clock);
        #1;
        if (Reset && bus.WriteSignal &&
            (bus.WriteRegister != lastWr || bus.WriteData != lastWd)) begin
            regs[bus.WriteRegister] = bus.WriteData;
            writeCount++;
        end
        lastWr = bus.WriteRegister;
        lastWd = bus.WriteData;
    endtask

    // Run one instruction from its first fetch cycle through WB_DATA
    task automatic runInstr(output int lat, output logic [2:0] armWr, output logic [7:0] armWd,
                            output logic [2:0] gotWr, output logic [7:0] gotWd,
                            output logic gotCarry, output int glitches);
        int         n = 0;
        int         wsCount = 0;
        logic       prevReq = 1'b0;
        logic [7:0] prevAddr;
        bit         done = 0;
        lat = 0; armWr = '1; armWd = '1; gotWr = '1; gotWd = '1; gotCarry = 1'bx; glitches = 0;
        prevAddr = bus.InstrAddr;
        while (!done && n < 40) begin
            n++;
            if (prevReq && bus.InstrReq && bus.InstrAddr != prevAddr) glitches++;
            if (prevReq && !bus.InstrReq && !bus.InstrValid) glitches++;
            prevReq  = bus.InstrReq;
            prevAddr = bus.InstrAddr;
            if (bus.WriteSignal) begin
                wsCount++;
                if (wsCount == 1) begin
                    armWr = bus.WriteRegister;
                    armWd = bus.WriteData;
                end else begin
                    gotWr = bus.WriteRegister;
                    gotWd = bus.WriteData;
`ifdef CARRY_FLAG_EN
                    gotCarry = Carry;
`else
                    gotCarry = 1'b0;
`endif
                    lat  = n;
                    done = 1;
                end
            end
            stepCycle();
        end
    endtask

    // Assert reset between clock edges
    task automatic assertReset();
        #2;
        Reset = 1'b0;
        bus.InstrValid = 1'b0;
        bus.InstrData  = 8'h00;
        reqPrev = 1'b0;
        reqAge  = 0;
        #1;
        lastWr = bus.WriteRegister;
        lastWd = bus.WriteData;
    endtask

    task automatic releaseReset(input string tag);
        #2 Reset = 1'b1;
        @(posedge Clock);
        #1;
        check({tag, "_restart_req"}, bus.InstrReq, 1);
        check({tag, "_restart_addr"}, bus.InstrAddr, RESET_PC_TB);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        vecRec      vecs [7];
        int         lat, glitches, wsSeen, reqAfterHalt, wsDuringHalt, wcBefore;
        logic [2:0] armWr, gotWr, prevWr;
        logic [7:0] armWd, gotWd, prevWd;
        logic       gotCarry, haltedSeen;
        bit         found;

        vecs[0] = '{"mov_r3_r5",       3'd3, 8'h05,  6, 8'hFE, 3'd5, 1'b0};
        vecs[1] = '{"add_r2_r6",       3'd2, ADD_WD, 7, 8'hFF, 3'd2, ADD_C};
        vecs[2] = '{"sub_r1_r7",       3'd1, 8'hFA,  7, 8'h00, 3'd1, 1'b1};
        vecs[3] = '{"ldi_r4_wait3",    3'd4, 8'hA5, 10, 8'h02, 3'd1, 1'b1};
        vecs[4] = '{"ldi_r1",          3'd1, 8'h3C,  7, 8'h04, 3'd1, 1'b1};
        vecs[5] = '{"add_r1_r4",       3'd1, 8'hE1,  7, 8'h05, 3'd1, 1'b0};
        vecs[6] = '{"mov_r0_r4_wait2", 3'd0, 8'hA5,  8, 8'h06, 3'd4, 1'b0};

        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'h00;
            memWait[i] = 0;
        end
        mem[8'hFD] = 8'h1D;  // MOV r3<-r5
        mem[8'hFE] = 8'h56;  // ADD r2<-r2+r6
        mem[8'hFF] = 8'h8F;  // SUB r1<-r1-r7
        mem[8'h00] = 8'hE0;  // LDI r4
        mem[8'h01] = 8'hA5;
        mem[8'h02] = 8'hC8;  // LDI r1
        mem[8'h03] = 8'h3C;
        mem[8'h04] = 8'h4C;  // ADD r1<-r1+r4
        mem[8'h05] = 8'h04;  // MOV r0<-r4
        mem[8'h06] = 8'hFF;  // HALT
        memWait[8'h01] = 3;
        memWait[8'h05] = 2;

        for (int i = 0; i < 8; i++) regs[i] = 8'(i);
`ifdef CARRY_FLAG_EN
        regs[2] = 8'hFF;
        regs[6] = 8'h02;
`endif
        bus.InstrValid = 1'b0;
        bus.InstrData  = 8'h00;

        #1 Reset = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        check("rst_addr", bus.InstrAddr, RESET_PC_TB);
        check("rst_req", bus.InstrReq, 0);
        check("rst_ws", bus.WriteSignal, 0);
        check("rst_wr", bus.WriteRegister, 0);
        check("rst_wd", bus.WriteData, 0);
        check("rst_rr", bus.ReadRegister, 0);
        check("rst_halted", bus.Halted, 0);
`ifdef CARRY_FLAG_EN
        check("rst_carry", Carry, 0);
`endif

        // Valid offered while not requesting must not start a fetch
        #2 Reset = 1'b1;
        bus.InstrValid = 1'b1;
        bus.InstrData  = 8'hFF;
        @(posedge Clock);
        #1;
        check("first_edge_req", bus.InstrReq, 1);
        check("stray_valid_ignored_addr", bus.InstrAddr, RESET_PC_TB);

        prevWr = '0;
        prevWd = '0;
        for (int v = 0; v < 7; v++) begin
            runInstr(lat, armWr, armWd, gotWr, gotWd, gotCarry, glitches);
            check({vecs[v].name, "_arm_hold"}, {armWr, armWd}, {prevWr, prevWd});
            check({vecs[v].name, "_wr"}, gotWr, vecs[v].wr);
            check({vecs[v].name, "_wd"}, gotWd, vecs[v].wd);
            check({vecs[v].name, "_latency"}, lat, vecs[v].lat);
            check({vecs[v].name, "_ws_low_after"}, bus.WriteSignal, 0);
            check({vecs[v].name, "_req_after"}, bus.InstrReq, 1);
            check({vecs[v].name, "_pc_after"}, bus.InstrAddr, vecs[v].pcAfter);
            check({vecs[v].name, "_hold_after"}, {bus.WriteRegister, bus.WriteData}, {vecs[v].wr, vecs[v].wd});
            check({vecs[v].name, "_rr_after"}, bus.ReadRegister, vecs[v].rrAfter);
            check({vecs[v].name, "_fetch_stable"}, glitches, 0);
`ifdef CARRY_FLAG_EN
            check({vecs[v].name, "_carry"}, gotCarry, vecs[v].carry);
`endif
            prevWr = vecs[v].wr;
            prevWd = vecs[v].wd;
        end
        check("file_r3", regs[3], 8'h05);
        check("file_r4", regs[4], 8'hA5);
        check("file_r0", regs[0], 8'hA5);
        check("write_count", writeCount, 7);

        // HALT: no requests and no writes for 20+ cycles
        haltedSeen = 0; reqAfterHalt = 0; wsDuringHalt = 0;
        for (int c = 0; c < 24; c++) begin
            if (bus.Halted) haltedSeen = 1;
            if (haltedSeen && bus.InstrReq) reqAfterHalt++;
            if (bus.WriteSignal) wsDuringHalt++;
            stepCycle();
        end
        check("halt_flag", bus.Halted, 1);
        check("halt_req_quiet", reqAfterHalt, 0);
        check("halt_no_ws", wsDuringHalt, 0);
        check("halt_pc", bus.InstrAddr, 8'h07);
        check("halt_write_count", writeCount, 7);
        assertReset();
        check("halt_rst_flag", bus.Halted, 0);
        check("halt_rst_addr", bus.InstrAddr, RESET_PC_TB);
        releaseReset("halt");

        // Reset during WB_ARM: enable falls at once and nothing commits
        found = 0;
        wcBefore = writeCount;
        for (int c = 0; c < 20 && !found; c++) begin
            if (bus.WriteSignal) found = 1;
            else stepCycle();
        end
        check("wbarm_reached", found, 1);
        assertReset();
        check("wbarm_rst_ws", bus.WriteSignal, 0);
        check("wbarm_rst_req", bus.InstrReq, 0);
        check("wbarm_no_commit", writeCount, wcBefore);
        releaseReset("wbarm");

        // Reset during a waiting fetch: request drops asynchronously
        memWait[8'hFD] = 5;
        repeat (3) stepCycle();
        check("wait_req_held", bus.InstrReq, 1);
        check("wait_addr_held", bus.InstrAddr, RESET_PC_TB);
        assertReset();
        check("wait_rst_req", bus.InstrReq, 0);
        memWait[8'hFD] = 0;
        releaseReset("wait");
        runInstr(lat, armWr, armWd, gotWr, gotWd, gotCarry, glitches);
        check("restart_mov_wr", gotWr, 3);
        check("restart_mov_wd", gotWd, 8'h05);
        check("restart_mov_latency", lat, 6);
        check("restart_pc_after", bus.InstrAddr, 8'hFE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
